// File: rtl/perceptron_evaluator_if.sv
// Handshake and progress signals between the evaluator and its controller.
// The evaluator takes the slave side; whoever issues start takes the master side.
interface perceptron_evaluator_if;
  logic start;
  logic busy;
  logic done;
  int   sample_idx;
  int   correct_count;

  modport master (output start, input busy, input done, input sample_idx, input correct_count);
  modport slave  (input start, output busy, output done, output sample_idx, output correct_count);
endinterface

// File: rtl/perceptron_evaluator.sv
// Sequences a fixed test set through an external perceptron, one sample per
// Drive/Sample pair, accumulating classification hits and squared error.
module perceptron_evaluator #(
  parameter int size = 2,
  parameter int num  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  perceptron_evaluator_if.slave  bus,
  input  real                    threshold,
  input  real                    test_values [num-1:0][size-1:0],
  input  real                    expected [num-1:0],
  input  real                    prediction,
  output real                    values [size-1:0],
  output real                    sum_sq_error,
  output real                    mse
);

  localparam int IW = (num > 1) ? $clog2(num) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  real             values_q [size-1:0];
  real             values_d [size-1:0];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  int              sample_idx_q, sample_idx_d;
  int              correct_count_q, correct_count_d;
  real             sse_q, sse_d;
  real             mse_q, mse_d;
  real             err_s;
  logic [IW-1:0]   sel_s;

  // Next-state and datapath updates for the evaluation sequencer.
  always_comb begin
    state_d         = state_q;
    values_d        = values_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    sample_idx_d    = sample_idx_q;
    correct_count_d = correct_count_q;
    sse_d           = sse_q;
    mse_d           = mse_q;
    err_s           = 0.0;
    sel_s           = IW'(sample_idx_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d         = ST_DRIVE;
          busy_d          = 1'b1;
          sample_idx_d    = 32'sd0;
          correct_count_d = 32'sd0;
          sse_d           = 0.0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        for (int i = 0; i < size; i++) begin
          values_d[i] = test_values[sel_s][i];
        end
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // prediction is the perceptron's response to values_q registered in Drive
        err_s = expected[sel_s] - prediction;
        sse_d = sse_q + err_s * err_s;
        if ((prediction >= threshold) == (expected[sel_s] >= threshold)) begin
          correct_count_d = correct_count_q + 32'sd1;
        end else begin
          correct_count_d = correct_count_q;
        end
        if (sample_idx_q < num - 1) begin
          sample_idx_d = sample_idx_q + 32'sd1;
          state_d      = ST_DRIVE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        mse_d   = sse_q / real'(num);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      for (int i = 0; i < size; i++) begin
        values_q[i] <= 0.0;
      end
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      sample_idx_q    <= 32'sd0;
      correct_count_q <= 32'sd0;
      sse_q           <= 0.0;
      mse_q           <= 0.0;
    end else begin
      state_q         <= state_d;
      values_q        <= values_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      sample_idx_q    <= sample_idx_d;
      correct_count_q <= correct_count_d;
      sse_q           <= sse_d;
      mse_q           <= mse_d;
    end
  end

  assign values            = values_q;
  assign sum_sq_error      = sse_q;
  assign mse               = mse_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sample_idx    = sample_idx_q;
  assign bus.correct_count = correct_count_q;

endmodule

// File: doc/perceptron_evaluator.md
PERCEPTRON_EVALUATOR -- requirements
Module: perceptron_evaluator

Interface
REQ-001 Parameter: size, 2, number of inputs per sample; equals the perceptron's size.
REQ-002 Parameter: num, 4, number of test samples; num >= 1.
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request an evaluation pass; sampled only in Idle.
REQ-006 Port: threshold  input  real  class boundary applied to prediction and expected.
REQ-007 Port: test_values  input  real[num-1:0][size-1:0]  test inputs; held stable while busy.
REQ-008 Port: expected  input  real[num-1:0]  target per sample; held stable while busy.
REQ-009 Port: prediction  input  real  combinational output of the perceptron's inference path.
REQ-010 Port: values  output  real[size-1:0]  registered drive into the perceptron's values input.
REQ-011 Port: busy  output  1  high while a pass is in progress.
REQ-012 Port: done  output  1  one-cycle pulse at end of pass.
REQ-013 Port: sample_idx  output  int  index of the sample currently driven.
REQ-014 Port: correct_count  output  int  samples classified correctly in the last or current pass.
REQ-015 Port: sum_sq_error  output  real  accumulated squared error.
REQ-016 Port: mse  output  real  sum_sq_error / num; updated only at pass end.

Function
REQ-017 The FSM SHALL have the states Idle, Drive, Sample and Finish.
REQ-018 Idle with start=1 SHALL move to Drive and set busy=1, sample_idx=0, correct_count=0 and sum_sq_error=0; mse SHALL be held.
REQ-019 Drive SHALL register values[i] <= test_values[sample_idx][i] for all i and move to Sample.
REQ-020 Sample SHALL compute err = expected[sample_idx] - prediction and add err*err to sum_sq_error.
REQ-021 Sample SHALL increment correct_count when (prediction >= threshold) == (expected[sample_idx] >= threshold).
REQ-022 Sample with sample_idx < num-1 SHALL increment sample_idx and move to Drive; with sample_idx = num-1 it SHALL move to Finish.
REQ-023 Finish SHALL register mse <= final sum_sq_error / num, pulse done=1 for exactly one cycle, clear busy and return to Idle.
REQ-024 Latency: done SHALL be high in the cycle following the edge that is 2*num+1 edges after the edge that sampled start.
REQ-025 Start while busy SHALL be ignored, with no restart and no extra done.
REQ-026 Start held high SHALL produce back-to-back passes, with done pulses exactly 2*num+2 cycles apart.
REQ-027 num=1 SHALL take the path Idle->Drive->Sample->Finish with sample_idx fixed at 0.
REQ-028 Outputs SHALL hold their last values in Idle until the next accepted start.
REQ-029 All arithmetic SHALL be real; correct_count and sample_idx SHALL be int and never exceed num and num-1 respectively.

Reset
REQ-030 rst=1 SHALL immediately force state to Idle and drive values to all 0.0, busy=0, done=0, sample_idx=0, correct_count=0, sum_sq_error=0.0 and mse=0.0.
REQ-031 Reset during a pass SHALL abort it with no done pulse; the first start after rst deasserts SHALL run a complete fresh pass.

Verification
REQ-032 The bench SHALL model prediction = values[0] and use size=2, num=4, threshold=0.5, test_values {0,0},{0,1},{1,0},{1,1} and expected {0,0,1,1}; one start pulse -> done 9 cycles later, correct_count=4, sum_sq_error=0.0, mse=0.0.
REQ-033 Same setup with expected {1,1,1,1} -> correct_count=2, sum_sq_error=2.0, mse=0.5.
REQ-034 Same setup with start re-pulsed at cycles 3 and 5 of a pass -> exactly one done, and results identical to REQ-032.
REQ-035 Same setup with rst asserted at cycle 4 of a pass -> all outputs 0 immediately and no done; the next start completes with the REQ-032 results.
REQ-036 Same setup with start held high for 30 cycles -> done pulses 10 cycles apart, each with the REQ-032 results.
REQ-037 Same model with num=1, test_values {{0.8,0}}, expected {1.0} -> correct_count=1, sum_sq_error=0.04 (±1e-9), mse=0.04, done 3 cycles after start.
